// File: rtl/vpu_pkg.sv
// Shared types for the VPU element sequencer: ALU control, element width, rounding, FSM states.
// No logic besides the sew_bits helper.
// Imported by every file of the sequencer slice.
package vpu_pkg;

    typedef enum logic [2:0] {
        VADD  = 3'd0,
        VSUB  = 3'd1,
        VAND  = 3'd2,
        VOR   = 3'd3,
        VXOR  = 3'd4,
        VMSEQ = 3'd5,
        VMSNE = 3'd6
    } valu_opcode_e;

    // MASK_WRITE: the ALU gates its write enable with v0[i]
    typedef enum logic [1:0] {
        MASK_NONE  = 2'd0,
        MASK_WRITE = 2'd1,
        MASK_CARRY = 2'd2
    } op_mask_e;

    typedef struct packed {
        valu_opcode_e op;
        op_mask_e     op_mask;
        logic         signext;
    } VALU_OP_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } VSEW_e;

    typedef enum logic [1:0] {
        RNU = 2'd0,
        RNE = 2'd1,
        RDN = 2'd2,
        ROD = 2'd3
    } VXRM_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Element width in bits: 8, 16, 32 or 64
    function automatic logic [6:0] sew_bits(input VSEW_e sew);
        return 7'd8 << sew;
    endfunction

endpackage

// File: rtl/vpu_elem_extract.sv
// Picks element idx of width SEW out of a vector register and zero-extends it to ELEN.
// Purely combinational, zero latency.
// No handshake; the caller decides when the element is consumed.
module vpu_elem_extract
    import vpu_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int IDXW = 5
) (
    input  logic [VLEN-1:0] data_i,
    input  logic [IDXW-1:0] idx_i,
    input  VSEW_e           vsew_i,
    output logic [ELEN-1:0] elem_o
);

    localparam int SHW = IDXW + 7;

    logic [SHW-1:0]  shamt;
    logic [VLEN-1:0] shifted;

    // Element i lives at bits [i*SEW +: SEW]; no sign extension here
    always_comb begin
        shamt   = SHW'(idx_i) * SHW'(sew_bits(vsew_i));
        shifted = data_i >> shamt;
        case (vsew_i)
            SEW8:    elem_o = ELEN'(shifted[7:0]);
            SEW16:   elem_o = ELEN'(shifted[15:0]);
            SEW32:   elem_o = ELEN'(shifted[31:0]);
            default: elem_o = ELEN'(shifted[63:0]);
        endcase
    end

endmodule

// File: rtl/vpu_alu_seq.sv
// Steps one vector ALU instruction element by element (vstart..vl-1) and packs results into vd.
// Latency: (vl-vstart)+1 cycles from issue accept to wb_valid_o; 1 cycle when no elements.
// Accepts issue only in IDLE; holds vd on wb_data_o until wb_ready_i; flush drops the instruction.
module vpu_alu_seq
    import vpu_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  VALU_OP_t                    valu_ctrl_i,
    input  VSEW_e                       vsew_i,
    input  VXRM_e                       vxrm_i,
    input  logic [$clog2(VLEN/8):0]     vl_i,
    input  logic [$clog2(VLEN/8)-1:0]   vstart_i,
    input  logic                        op1_sel_i,
    input  logic                        mask_dst_i,
    input  logic [VLEN-1:0]             vs1_i,
    input  logic [VLEN-1:0]             vs2_i,
    input  logic [VLEN-1:0]             v0_i,
    input  logic [VLEN-1:0]             vd_old_i,
    input  logic [ELEN-1:0]             scalar_i,
    output logic                        alu_valid_o,
    output VALU_OP_t                    alu_ctrl_o,
    output VSEW_e                       alu_vsew_o,
    output VXRM_e                       alu_vxrm_o,
    output logic [ELEN-1:0]             alu_op1_o,
    output logic [ELEN-1:0]             alu_op2_o,
    output logic                        alu_mask_o,
    input  logic                        alu_rvalid_i,
    input  logic                        alu_ren_i,
    input  logic [ELEN-1:0]             alu_result_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [VLEN-1:0]             wb_data_o
);

    localparam int VLW  = $clog2(VLEN/8) + 1;
    localparam int BITW = $clog2(VLEN);
    localparam int SHW  = VLW + 7;

    seq_state_e      state_q, state_d;
    logic [VLW-1:0]  idx_q, idx_d;
    logic [VLW-1:0]  vl_q;
    logic [VLEN-1:0] vd_q, vd_d;
    VALU_OP_t        ctrl_q;
    VSEW_e           vsew_q;
    VXRM_e           vxrm_q;
    logic            op1_sel_q, mask_dst_q;
    logic [VLEN-1:0] vs1_q, vs2_q, v0_q;
    logic [ELEN-1:0] scalar_q;

    logic            accept;
    logic [VLW-1:0]  vlmax, vl_eff;
    logic [ELEN-1:0] sew_mask;
    logic [SHW-1:0]  shamt;
    logic [VLEN-1:0] slice_mask, merged;
    logic [ELEN-1:0] elem1, elem2;
    logic            run, done;

    // Clamp the requested length to what fits in one register at the issued SEW
    always_comb begin
        case (vsew_i)
            SEW8:    vlmax = VLW'(VLEN/8);
            SEW16:   vlmax = VLW'(VLEN/16);
            SEW32:   vlmax = VLW'(VLEN/32);
            default: vlmax = VLW'(VLEN/64);
        endcase
        vl_eff = (!mask_dst_i && (vl_i > vlmax)) ? vlmax : vl_i;
    end

    // Result merge: one SEW slice, or one bit for mask destinations
    always_comb begin
        case (vsew_q)
            SEW8:    sew_mask = ELEN'(8'hFF);
            SEW16:   sew_mask = ELEN'(16'hFFFF);
            SEW32:   sew_mask = ELEN'(32'hFFFF_FFFF);
            default: sew_mask = '1;
        endcase
        shamt      = SHW'(idx_q) * SHW'(sew_bits(vsew_q));
        slice_mask = VLEN'(sew_mask) << shamt;
        merged     = vd_q;
        if (mask_dst_q) begin
            merged[BITW'(idx_q)] = alu_result_i[0];
        end else begin
            merged = (vd_q & ~slice_mask) | (VLEN'(alu_result_i & sew_mask) << shamt);
        end
    end

    // Next-state, element index and vd buffer; flush overrides everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vd_d    = vd_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid_i) begin
                    accept  = 1'b1;
                    idx_d   = VLW'(vstart_i);
                    vd_d    = vd_old_i;
                    state_d = ((vl_eff == '0) || (VLW'(vstart_i) >= vl_eff)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (alu_rvalid_i && alu_ren_i) begin
                    vd_d = merged;
                end
                idx_d = idx_q + VLW'(1);
                if (idx_q == vl_q - VLW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
            accept  = 1'b0;
        end
    end

    // State, buffer and latched issue fields
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            vl_q       <= '0;
            vd_q       <= '0;
            ctrl_q     <= '0;
            vsew_q     <= SEW8;
            vxrm_q     <= RNU;
            op1_sel_q  <= 1'b0;
            mask_dst_q <= 1'b0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            v0_q       <= '0;
            scalar_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vd_q    <= vd_d;
            if (accept) begin
                vl_q       <= vl_eff;
                ctrl_q     <= valu_ctrl_i;
                vsew_q     <= vsew_i;
                vxrm_q     <= vxrm_i;
                op1_sel_q  <= op1_sel_i;
                mask_dst_q <= mask_dst_i;
                vs1_q      <= vs1_i;
                vs2_q      <= vs2_i;
                v0_q       <= v0_i;
                scalar_q   <= scalar_i;
            end
        end
    end

    vpu_elem_extract #(.VLEN(VLEN), .ELEN(ELEN), .IDXW(VLW)) u_ext_vs1 (
        .data_i (vs1_q),
        .idx_i  (idx_q),
        .vsew_i (vsew_q),
        .elem_o (elem1)
    );

    vpu_elem_extract #(.VLEN(VLEN), .ELEN(ELEN), .IDXW(VLW)) u_ext_vs2 (
        .data_i (vs2_q),
        .idx_i  (idx_q),
        .vsew_i (vsew_q),
        .elem_o (elem2)
    );

    assign run           = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign issue_ready_o = (state_q == IDLE);
    assign alu_valid_o   = run;
    assign alu_ctrl_o    = ctrl_q;
    assign alu_vsew_o    = vsew_q;
    assign alu_vxrm_o    = vxrm_q;
    assign alu_op1_o     = run ? (op1_sel_q ? scalar_q : elem1) : '0;
    assign alu_op2_o     = run ? elem2 : '0;
    assign alu_mask_o    = run & v0_q[BITW'(idx_q)];
    assign wb_valid_o    = done;
    assign wb_data_o     = done ? vd_q : '0;

endmodule

// File: tb/tb_vpu_alu_seq.sv
module tb_vpu_alu_seq;
    import vpu_pkg::*;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    VALU_OP_t        valu_ctrl_i;
    VSEW_e           vsew_i;
    VXRM_e           vxrm_i;
    logic [4:0]      vl_i;
    logic [3:0]      vstart_i;
    logic            op1_sel_i, mask_dst_i;
    logic [127:0]    vs1_i, vs2_i, v0_i, vd_old_i;
    logic [63:0]     scalar_i;
    logic            alu_valid_o;
    VALU_OP_t        alu_ctrl_o;
    VSEW_e           alu_vsew_o;
    VXRM_e           alu_vxrm_o;
    logic [63:0]     alu_op1_o, alu_op2_o;
    logic            alu_mask_o;
    logic            alu_rvalid_i, alu_ren_i;
    logic [63:0]     alu_result_i;
    logic            wb_valid_o, wb_ready_i;
    logic [127:0]    wb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vpu_alu_seq #(.VLEN(128), .ELEN(64)) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .valu_ctrl_i(valu_ctrl_i), .vsew_i(vsew_i), .vxrm_i(vxrm_i),
        .vl_i(vl_i), .vstart_i(vstart_i), .op1_sel_i(op1_sel_i), .mask_dst_i(mask_dst_i),
        .vs1_i(vs1_i), .vs2_i(vs2_i), .v0_i(v0_i), .vd_old_i(vd_old_i), .scalar_i(scalar_i),
        .alu_valid_o(alu_valid_o), .alu_ctrl_o(alu_ctrl_o), .alu_vsew_o(alu_vsew_o),
        .alu_vxrm_o(alu_vxrm_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
        .alu_mask_o(alu_mask_o), .alu_rvalid_i(alu_rvalid_i), .alu_ren_i(alu_ren_i),
        .alu_result_i(alu_result_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_data_o(wb_data_o)
    );

    // Single-element ALU behaviour (the neighbour block, not the DUT)
    function automatic logic [63:0] alu_fn(input valu_opcode_e op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            VADD:    return a + b;
            VSUB:    return a - b;
            VAND:    return a & b;
            VOR:     return a | b;
            VXOR:    return a ^ b;
            VMSEQ:   return {63'd0, a == b};
            VMSNE:   return {63'd0, a != b};
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        alu_rvalid_i = alu_valid_o;
        alu_ren_i    = (alu_ctrl_o.op_mask == MASK_WRITE) ? alu_mask_o : 1'b1;
        alu_result_i = alu_fn(alu_ctrl_o.op, alu_op1_o, alu_op2_o);
    end

    // Reference: what vd must hold after the whole instruction
    function automatic logic [127:0] ref_vd(input VALU_OP_t c, input VSEW_e s, input int vl, input int vstart,
                                            input logic osel, input logic mdst,
                                            input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] m, input logic [127:0] old,
                                            input logic [63:0] sc);
        int sew = 8 << int'(s);
        int limit = mdst ? 128 : 128 / sew;
        int n = (vl < limit) ? vl : limit;
        logic [127:0] r = old;
        logic [63:0] mk = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
        logic [63:0] x, y, res;
        for (int i = vstart; i < n; i++) begin
            if (c.op_mask != MASK_WRITE || m[i]) begin
                x   = osel ? sc : (64'(a >> (i * sew)) & mk);
                y   = 64'(b >> (i * sew)) & mk;
                res = alu_fn(c.op, x, y);
                if (mdst) r[i] = res[0];
                else for (int k = 0; k < sew; k++) r[i * sew + k] = res[k];
            end
        end
        return r;
    endfunction

    function automatic int ref_lat(input VSEW_e s, input int vl, input int vstart, input logic mdst);
        int limit = mdst ? 128 : 128 / (8 << int'(s));
        int n = (vl < limit) ? vl : limit;
        return (n > vstart) ? (n - vstart + 1) : 1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, wait for writeback (bounded), optionally stall, then release
    task automatic run_op(input string tag, input VALU_OP_t c, input VSEW_e s, input int vl, input int vs,
                          input logic osel, input logic mdst,
                          input logic [127:0] a, input logic [127:0] b, input logic [127:0] m,
                          input logic [127:0] old, input logic [63:0] sc,
                          input int hold, input logic early,
                          output logic [127:0] got, output int lat);
        logic [127:0] first;
        chk({tag, ".issue_rdy"}, 128'(issue_ready_o), 128'd1);
        valu_ctrl_i = c; vsew_i = s; vxrm_i = VXRM_e'($urandom_range(0, 3));
        vl_i = 5'(vl); vstart_i = 4'(vs); op1_sel_i = osel; mask_dst_i = mdst;
        vs1_i = a; vs2_i = b; v0_i = m; vd_old_i = old; scalar_i = sc;
        issue_valid_i = 1'b1;
        wb_ready_i = early;
        @(negedge clk);
        issue_valid_i = 1'b0;
        vd_old_i = ~old;
        lat = 1;
        while (!wb_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got   = wb_data_o;
        first = wb_data_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_vld"}, 128'(wb_valid_o), 128'd1);
            chk({tag, ".hold_dat"}, wb_data_o, first);
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk({tag, ".released"}, 128'(wb_valid_o), 128'd0);
        chk({tag, ".rdy_after"}, 128'(issue_ready_o), 128'd1);
    endtask

    initial begin
        VALU_OP_t     c;
        logic [127:0] a, b, m, old, exp, got;
        logic [63:0]  sc;
        int           lat, seen, vl, vs;
        VSEW_e        s;
        logic         osel, mdst, early;
        valu_opcode_e ops [4] = '{VADD, VAND, VXOR, VMSEQ};

        rstn = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; wb_ready_i = 1'b0;
        valu_ctrl_i = '0; vsew_i = SEW8; vxrm_i = RNU; vl_i = '0; vstart_i = '0;
        op1_sel_i = 1'b0; mask_dst_i = 1'b0; vs1_i = '0; vs2_i = '0; v0_i = '0;
        vd_old_i = '0; scalar_i = '0;
        repeat (2) @(negedge clk);
        chk("rst.issue_rdy", 128'(issue_ready_o), 128'd1);
        chk("rst.wb_vld", 128'(wb_valid_o), 128'd0);
        chk("rst.alu_vld", 128'(alu_valid_o), 128'd0);
        chk("rst.wb_dat", wb_data_o, 128'd0);
        chk("rst.alu_ops", {alu_op1_o, alu_op2_o}, 128'd0);
        rstn = 1'b1;
        @(negedge clk);

        // 1) SEW8 vl=16 VADD, byte i = i + 2i
        for (int i = 0; i < 16; i++) begin
            a[i*8 +: 8] = 8'(i); b[i*8 +: 8] = 8'(2 * i); exp[i*8 +: 8] = 8'(3 * i);
        end
        c = '{op: VADD, op_mask: MASK_NONE, signext: 1'b0};
        run_op("t1", c, SEW8, 16, 0, 1'b0, 1'b0, a, b, '1, '0, '0, 0, 1'b0, got, lat);
        chk("t1.lat", 128'(lat), 128'd17);
        chk("t1.vd", got, exp);

        // 2) SEW32 vl=3 masked VADD, v0=0101, vd_old all 0xAA
        a = {32'h0, 32'h1000_0001, 32'h7, 32'hFFFF_FFF0};
        b = {32'h5, 32'h2222_2222, 32'h3, 32'h0000_0020};
        c = '{op: VADD, op_mask: MASK_WRITE, signext: 1'b0};
        run_op("t2", c, SEW32, 3, 0, 1'b0, 1'b0, a, b, 128'b0101, {16{8'hAA}}, '0, 0, 1'b0, got, lat);
        chk("t2.lat", 128'(lat), 128'd4);
        chk("t2.vd", got, {32'hAAAA_AAAA, 32'h3222_2223, 32'hAAAA_AAAA, 32'h0000_0010});

        // 3) SEW16 vl=8 VMSEQ into mask bits, equal on even indices
        for (int i = 0; i < 8; i++) begin
            a[i*16 +: 16] = 16'(100 + i);
            b[i*16 +: 16] = (i % 2 == 0) ? 16'(100 + i) : 16'(200 + i);
        end
        c = '{op: VMSEQ, op_mask: MASK_NONE, signext: 1'b0};
        run_op("t3", c, SEW16, 8, 0, 1'b0, 1'b1, a, b, '0, '1, '0, 0, 1'b0, got, lat);
        chk("t3.vd", got, {{120{1'b1}}, 8'h55});

        // 4) empty instructions: vl=0, and vstart=vl=5
        old = {4{32'hDEAD_BEEF}};
        c = '{op: VADD, op_mask: MASK_NONE, signext: 1'b0};
        run_op("t4a", c, SEW8, 0, 0, 1'b0, 1'b0, '1, '1, '1, old, '0, 0, 1'b0, got, lat);
        chk("t4a.lat", 128'(lat), 128'd1);
        chk("t4a.vd", got, old);
        run_op("t4b", c, SEW8, 5, 5, 1'b0, 1'b0, '1, '1, '1, old, '0, 0, 1'b0, got, lat);
        chk("t4b.lat", 128'(lat), 128'd1);
        chk("t4b.vd", got, old);

        // 5) SEW64 vl=2 VAND with all-ones scalar, 4-cycle writeback stall
        b = {$urandom, $urandom, $urandom, $urandom};
        c = '{op: VAND, op_mask: MASK_NONE, signext: 1'b0};
        run_op("t5", c, SEW64, 2, 0, 1'b1, 1'b0, '0, b, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b0, got, lat);
        chk("t5.lat", 128'(lat), 128'd3);
        chk("t5.vd", got, b);

        // 6) flush on the third RUN cycle, then a clean instruction
        vsew_i = SEW8; vl_i = 5'd16; vstart_i = 4'd0; valu_ctrl_i = '{op: VADD, op_mask: MASK_NONE, signext: 1'b0};
        mask_dst_i = 1'b0; op1_sel_i = 1'b0; issue_valid_i = 1'b1;
        @(negedge clk);
        issue_valid_i = 1'b0;
        chk("t6.run", 128'(alu_valid_o), 128'd1);
        @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t6.rdy_after_flush", 128'(issue_ready_o), 128'd1);
        chk("t6.alu_idle", 128'(alu_valid_o), 128'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wb_valid_o) seen++;
            @(negedge clk);
        end
        chk("t6.no_wb", 128'(seen), 128'd0);
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = '{op: VXOR, op_mask: MASK_NONE, signext: 1'b0};
        run_op("t6n", c, SEW16, 8, 2, 1'b0, 1'b0, a, b, '0, '0, '0, 0, 1'b0, got, lat);
        chk("t6n.vd", got, ref_vd(c, SEW16, 8, 2, 1'b0, 1'b0, a, b, '0, '0, '0));
        chk("t6n.lat", 128'(lat), 128'd7);

        // Randomized instructions against the reference model
        for (int t = 0; t < 30; t++) begin
            c.op      = ops[$urandom_range(0, 3)];
            c.op_mask = ($urandom_range(0, 1) == 1) ? MASK_WRITE : MASK_NONE;
            c.signext = 1'($urandom_range(0, 1));
            s    = VSEW_e'($urandom_range(0, 3));
            vl   = $urandom_range(0, 16);
            vs   = $urandom_range(0, 15);
            osel = ($urandom_range(0, 3) == 0);
            mdst = (c.op == VMSEQ) && ($urandom_range(0, 1) == 1);
            early = ($urandom_range(0, 2) == 0);
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = ($urandom_range(0, 1) == 1) ? a : {$urandom, $urandom, $urandom, $urandom};
            m   = {$urandom, $urandom, $urandom, $urandom};
            old = {$urandom, $urandom, $urandom, $urandom};
            sc  = {$urandom, $urandom};
            run_op("rnd", c, s, vl, vs, osel, mdst, a, b, m, old, sc, 0, early, got, lat);
            chk("rnd.vd", got, ref_vd(c, s, vl, vs, osel, mdst, a, b, m, old, sc));
            chk("rnd.lat", 128'(lat), 128'(ref_lat(s, vl, vs, mdst)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
